data_mem_responder: RTL

Word-addressed data memory that answers the memory-side bus driven by the sub-word write synchronizer: 30-bit word address, chip select, read/write strobe and a shared 32-bit tristate data bus. It serves word reads and word writes from a synchronous RAM and inserts a configurable number of wait states. It raises `data_ready_o` when each access completes, so the initiator can sequence read-modify-write cycles.

---
 rtl/data_mem_responder_pkg.sv | 17 +
 rtl/data_mem_array.sv | 41 ++++
 rtl/data_mem_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data memory responder: FSM state encodings,
// bus width and read/write strobe encodings.
package data_mem_responder_pkg;

  localparam int BUS_W = 32;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous RAM, 2^ADDR_W x 32. Writes and reads both complete
// on the rising edge; rdata is a register that only loads when re is set, so
// it keeps the last word read (it is the responder's read-data register).
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BUS_W-1:0]  wdata,
  output logic [BUS_W-1:0]  rdata
);

  logic [BUS_W-1:0] mem [2**ADDR_W];
  logic [BUS_W-1:0] rdata_q;
  logic [BUS_W-1:0] rdata_d;

  // Storage array: not reset, written only on an enabled access edge
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Next read register value: load on a read access, otherwise hold
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  // Read register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder on a shared 32-bit tristate bus.
// Optional wait states are compiled in with DATA_MEM_WAIT_EN; without it
// every access completes one edge after the request is latched.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] data_address_i,
  input  logic        data_cs_i,
  input  logic        data_rw_i,
  inout  wire  [31:0] data_bus,
  output logic        data_ready_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic              lat_rw_q, lat_rw_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] idx;
  logic              take_req;
  logic              mem_we, mem_re;
  logic [BUS_W-1:0]  rd_reg;
  logic              bus_drv;

`ifdef DATA_MEM_WAIT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       unused_addr;
  assign unused_addr = ^data_address_i[29:ADDR_W];
`else
  logic unused_cfg;
  assign unused_cfg = ^{data_address_i[29:ADDR_W], 1'(WAIT_CYCLES)};
`endif

  // Upper address bits alias: only the low ADDR_W bits select a word
  assign idx = data_address_i[ADDR_W-1:0];

  // Next-state, latch and RAM-strobe logic
  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    lat_rw_d   = lat_rw_q;
    take_req   = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
`ifdef DATA_MEM_WAIT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (data_cs_i) take_req = 1'b1;
      end
`ifdef DATA_MEM_WAIT_EN
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!data_cs_i)       state_d = ST_IDLE;
        else if (cnt_q == 4'd1) state_d = ST_ACCESS;
      end
`endif
      ST_ACCESS: begin
        // Dropping CS before this edge abandons the access entirely
        if (!data_cs_i) begin
          state_d = ST_IDLE;
        end else begin
          mem_we  = (lat_rw_q == RW_WRITE) && !rst;
          mem_re  = (lat_rw_q == RW_READ);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A changed rw or address with CS held is a fresh request (RMW);
        // an unchanged one parks here so a write is never repeated.
        if (!data_cs_i)
          state_d = ST_IDLE;
        else if ((data_rw_i != lat_rw_q) || (idx != lat_addr_q))
          take_req = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_req) begin
      lat_addr_d = idx;
      lat_rw_d   = data_rw_i;
`ifdef DATA_MEM_WAIT_EN
      if (WAIT_CYCLES == 0) begin
        state_d = ST_ACCESS;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = 4'(WAIT_CYCLES);
      end
`else
      state_d = ST_ACCESS;
`endif
    end

    ready_d = (state_d == ST_DONE);
  end

  // State, latches and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lat_addr_q <= '0;
      lat_rw_q   <= 1'b0;
      ready_q    <= 1'b0;
`ifdef DATA_MEM_WAIT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      lat_rw_q   <= lat_rw_d;
      ready_q    <= ready_d;
`ifdef DATA_MEM_WAIT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  data_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (lat_addr_q),
    .wdata (data_bus),
    .rdata (rd_reg)
  );

  // Read data goes out only in DONE, for a read, while the initiator selects us
  assign bus_drv      = (state_q == ST_DONE) && (lat_rw_q == RW_READ) && data_cs_i;
  assign data_bus     = bus_drv ? rd_reg : 'z;
  assign data_ready_o = ready_q;

endmodule
